// File: rtl/rename_stage.sv
// Register-rename stage: speculative RAT, retirement RAT, free-list bitmap,
// ready (busy) table and a one-deep registered output toward the issue queue.
module rename_stage #(
    parameter int NUM_PHYS  = 64,
    parameter int NUM_ARCH  = 32,
    parameter int PAYLOAD_W = 152
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    FLUSH,
    input  logic                    STALL,
    input  logic                    dec_valid,
    input  logic [4:0]              dec_rs,
    input  logic [4:0]              dec_rt,
    input  logic [4:0]              dec_wr,
    input  logic                    dec_wr_flag,
    input  logic [PAYLOAD_W-1:0]    dec_payload,
    output logic                    rename_stall,
    output logic                    rename_enque,
    output logic [PAYLOAD_W+17:0]   rename_issueinfo,
    output logic [31:0]             rename_instr_num,
    output logic [5:0]              rename_old_map,
    output logic [NUM_PHYS-1:0]     busy,
    input  logic                    exe_broadcast,
    input  logic [5:0]              exe_broadcast_map,
    input  logic                    mem_broadcast,
    input  logic [5:0]              mem_broadcast_map,
    input  logic                    commit_valid,
    input  logic [4:0]              commit_arch,
    input  logic [5:0]              commit_new_map,
    input  logic [5:0]              commit_old_map
);

    logic [5:0]          rat       [NUM_ARCH];
    logic [5:0]          rrat      [NUM_ARCH];
    logic [5:0]          rrat_next [NUM_ARCH];
    logic [NUM_PHYS-1:0] free_map;
    logic [NUM_PHYS-1:0] free_next;
    logic [NUM_PHYS-1:0] flush_free;
    logic [NUM_PHYS-1:0] in_rrat;
    logic [NUM_PHYS-1:0] busy_tbl;
    logic [NUM_PHYS-1:0] busy_next;
    logic [NUM_PHYS-1:0] exe_hot;
    logic [NUM_PHYS-1:0] mem_hot;
    logic [31:0]         instr_cnt;
    logic                needs_alloc;
    logic                accept;
    logic [5:0]          new_map;
    logic [5:0]          map_a;
    logic [5:0]          map_b;
    logic [5:0]          map_wr;
    logic [5:0]          old_map;

    // Accept decision, lowest-free allocation and pre-update source lookup
    always_comb begin
        needs_alloc  = dec_wr_flag && (dec_wr != 5'd0);
        accept       = dec_valid && !STALL && !FLUSH && !(needs_alloc && (free_map == '0));
        rename_stall = dec_valid && !accept;
        new_map = 6'd0;
        for (int i = NUM_PHYS - 1; i >= 1; i--) begin
            if (free_map[i]) new_map = 6'(i);
        end
        map_a   = (dec_rs == 5'd0) ? 6'd0 : rat[dec_rs];
        map_b   = (dec_rt == 5'd0) ? 6'd0 : rat[dec_rt];
        map_wr  = needs_alloc ? new_map : 6'd0;
        old_map = needs_alloc ? rat[dec_wr] : 6'd0;
    end

    // Retirement RAT with this cycle's commit folded in, and the set of registers it still owns
    always_comb begin
        for (int i = 0; i < NUM_ARCH; i++) rrat_next[i] = rrat[i];
        if (commit_valid && commit_arch != 5'd0) rrat_next[commit_arch] = commit_new_map;
        in_rrat = '0;
        for (int i = 0; i < NUM_ARCH; i++) in_rrat[rrat_next[i]] = 1'b1;
        flush_free = ~in_rrat;
        flush_free[0] = 1'b0;
    end

    // Next free list and busy table in normal operation; allocation clear is applied last
    always_comb begin
        free_next = free_map;
        if (commit_valid && commit_old_map != 6'd0) free_next[commit_old_map] = 1'b1;
        if (accept && needs_alloc) free_next[new_map] = 1'b0;
        exe_hot = '0;
        mem_hot = '0;
        if (exe_broadcast && exe_broadcast_map != 6'd0) exe_hot[exe_broadcast_map] = 1'b1;
        if (mem_broadcast && mem_broadcast_map != 6'd0) mem_hot[mem_broadcast_map] = 1'b1;
        busy_next = busy_tbl | exe_hot | mem_hot;
        if (accept && needs_alloc) busy_next[new_map] = 1'b0;
        busy = busy_tbl | exe_hot | mem_hot;
    end

    // Speculative and retirement RATs; flush rebuilds the speculative map from retirement state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                rat[i]  <= 6'(i);
                rrat[i] <= 6'(i);
            end
        end else begin
            for (int i = 0; i < NUM_ARCH; i++) rrat[i] <= rrat_next[i];
            if (FLUSH) begin
                for (int i = 0; i < NUM_ARCH; i++) rat[i] <= rrat_next[i];
            end else if (accept && needs_alloc) begin
                rat[dec_wr] <= new_map;
            end
        end
    end

    // Free-list bitmap and busy table
    always_ff @(posedge CLK) begin
        if (RESET) begin
            free_map <= {{(NUM_PHYS - NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
            busy_tbl <= '1;
        end else if (FLUSH) begin
            free_map <= flush_free;
            busy_tbl <= '1;
        end else begin
            free_map <= free_next;
            busy_tbl <= busy_next;
        end
    end

    // Output register toward the issue queue plus the sequence counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rename_enque     <= 1'b0;
            rename_issueinfo <= '0;
            rename_instr_num <= '0;
            rename_old_map   <= '0;
            instr_cnt        <= '0;
        end else if (FLUSH) begin
            rename_enque <= 1'b0;
        end else if (!STALL) begin
            rename_enque <= accept;
            if (accept) begin
                rename_issueinfo <= {dec_payload, map_wr, map_b, map_a};
                rename_instr_num <= instr_cnt;
                rename_old_map   <= old_map;
                instr_cnt        <= instr_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_rename_stage.sv
// Randomized scoreboard bench for rename_stage with a behavioural rename model.
module tb_rename_stage;
    localparam int PW = 152;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          FLUSH = 1'b0, STALL = 1'b0, dec_valid = 1'b0;
    logic [4:0]    dec_rs = '0, dec_rt = '0, dec_wr = '0;
    logic          dec_wr_flag = 1'b0;
    logic [PW-1:0] dec_payload = '0;
    logic          rename_stall, rename_enque;
    logic [169:0]  rename_issueinfo;
    logic [31:0]   rename_instr_num;
    logic [5:0]    rename_old_map;
    logic [63:0]   busy;
    logic          exe_broadcast = 1'b0, mem_broadcast = 1'b0;
    logic [5:0]    exe_broadcast_map = '0, mem_broadcast_map = '0;
    logic          commit_valid = 1'b0;
    logic [4:0]    commit_arch = '0;
    logic [5:0]    commit_new_map = '0, commit_old_map = '0;

    rename_stage dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .STALL(STALL), .dec_valid(dec_valid),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_wr(dec_wr), .dec_wr_flag(dec_wr_flag),
        .dec_payload(dec_payload), .rename_stall(rename_stall), .rename_enque(rename_enque),
        .rename_issueinfo(rename_issueinfo), .rename_instr_num(rename_instr_num),
        .rename_old_map(rename_old_map), .busy(busy),
        .exe_broadcast(exe_broadcast), .exe_broadcast_map(exe_broadcast_map),
        .mem_broadcast(mem_broadcast), .mem_broadcast_map(mem_broadcast_map),
        .commit_valid(commit_valid), .commit_arch(commit_arch),
        .commit_new_map(commit_new_map), .commit_old_map(commit_old_map)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [169:0] info; logic [31:0] num; logic [5:0] old; } exp_t;
    typedef struct { logic [4:0] arch; logic [5:0] nmap; logic [5:0] omap; } rob_t;

    exp_t        sb[$];
    rob_t        rob[$];
    int          m_rat[32];
    int          m_rrat[32];
    bit          m_free[64];
    bit          m_busy[64];
    int unsigned m_count;
    int          tests = 0;
    int          fails = 0;
    exp_t        mon_e;

    task automatic check(input string name, input logic [169:0] act, input logic [169:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_rat[i]  = i;
            m_rrat[i] = i;
        end
        for (int p = 0; p < 64; p++) begin
            m_free[p] = (p >= 32);
            m_busy[p] = 1'b1;
        end
        m_count = 0;
        rob.delete();
        sb.delete();
    endfunction

    task automatic do_reset();
        RESET = 1'b1; FLUSH = 1'b0; STALL = 1'b0; dec_valid = 1'b0; dec_wr_flag = 1'b0;
        exe_broadcast = 1'b0; mem_broadcast = 1'b0; commit_valid = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_reset();
    endtask

    // One cycle: drive inputs, predict from the model, then advance the model across the edge
    task automatic applyStimulus(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] wr, input bit wf, input bit st, input bit fl,
                                 input bit cm, input bit eb, input logic [5:0] em,
                                 input bit mb, input logic [5:0] mm);
        bit            needs, has_free, acc;
        int            nm;
        logic [63:0]   bexp;
        logic [PW-1:0] pay;
        logic [5:0]    ma, mbm, mw, om;
        rob_t          c;
        exp_t          e;
        bit            used[64];
        c.arch = '0; c.nmap = '0; c.omap = '0;
        if (cm && rob.size() > 0) c = rob.pop_front();
        else cm = 1'b0;
        for (int k = 0; k < PW; k++) pay[k] = 1'($urandom_range(0, 1));
        dec_valid = v; dec_rs = rs; dec_rt = rt; dec_wr = wr; dec_wr_flag = wf;
        dec_payload = pay; STALL = st; FLUSH = fl;
        commit_valid = cm; commit_arch = c.arch; commit_new_map = c.nmap; commit_old_map = c.omap;
        exe_broadcast = eb; exe_broadcast_map = em; mem_broadcast = mb; mem_broadcast_map = mm;
        #1;
        needs = wf && (wr != 0);
        has_free = 1'b0;
        nm = 0;
        for (int p = 63; p >= 1; p--) if (m_free[p]) begin has_free = 1'b1; nm = p; end
        acc = v && !st && !fl && !(needs && !has_free);
        for (int p = 0; p < 64; p++)
            bexp[p] = m_busy[p] | (eb && em == p && p != 0) | (mb && mm == p && p != 0);
        check("rename_stall", 170'(rename_stall), 170'(v && !acc));
        check("busy", 170'(busy), 170'(bexp));
        ma  = 6'(m_rat[rs]);
        mbm = 6'(m_rat[rt]);
        mw  = needs ? 6'(nm) : 6'd0;
        om  = needs ? 6'(m_rat[wr]) : 6'd0;
        if (acc) begin
            e.info = {pay, mw, mbm, ma};
            e.num  = m_count;
            e.old  = om;
            sb.push_back(e);
        end
        if (cm && c.arch != 0) m_rrat[c.arch] = int'(c.nmap);
        if (fl) begin
            for (int p = 0; p < 64; p++) used[p] = 1'b0;
            for (int i = 0; i < 32; i++) begin
                m_rat[i] = m_rrat[i];
                used[m_rrat[i]] = 1'b1;
            end
            for (int p = 0; p < 64; p++) begin
                m_free[p] = (p != 0) && !used[p];
                m_busy[p] = 1'b1;
            end
            rob.delete();
        end else begin
            if (cm && c.omap != 0) m_free[c.omap] = 1'b1;
            if (eb && em != 0) m_busy[em] = 1'b1;
            if (mb && mm != 0) m_busy[mm] = 1'b1;
            if (acc && needs) begin
                m_free[nm] = 1'b0;
                m_busy[nm] = 1'b0;
                rob.push_back('{arch: wr, nmap: 6'(nm), omap: om});
                m_rat[wr] = nm;
            end
            if (acc) m_count++;
        end
        @(posedge CLK); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input string name, input logic [169:0] act, input logic [169:0] exp);
        check(name, act, exp);
    endtask

    // Monitor: the issue queue takes the output word on any edge where it is valid and not stalled
    always @(negedge CLK) begin
        if (!RESET && rename_enque === 1'b1 && STALL === 1'b0) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_enque: got 1 expected 0 at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("issueinfo", rename_issueinfo, mon_e.info);
                check("instr_num", 170'(rename_instr_num), 170'(mon_e.num));
                check("old_map", 170'(rename_old_map), 170'(mon_e.old));
            end
        end
    end

    initial begin
        logic [169:0] saved_info;
        logic [31:0]  saved_num;
        bit           st, fl, cm, eb, mb, v, wf;
        logic [5:0]   em, mm;

        // Reset state
        do_reset();
        checkOutput("reset_enque", 170'(rename_enque), 170'(0));
        checkOutput("reset_issueinfo", rename_issueinfo, 170'(0));
        checkOutput("reset_old_map", 170'(rename_old_map), 170'(0));
        checkOutput("reset_busy", 170'(busy), 170'({64{1'b1}}));

        // add r3,r1,r2 then r3=r3+r3 then a reader of r3 with a same-cycle wakeup of 33
        applyStimulus(1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("first_maps", 170'(rename_issueinfo[17:0]), 170'({6'd32, 6'd2, 6'd1}));
        checkOutput("first_old", 170'(rename_old_map), 170'(3));
        checkOutput("first_num", 170'(rename_instr_num), 170'(0));
        checkOutput("first_busy32", 170'(busy[32]), 170'(0));
        applyStimulus(1, 3, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("second_maps", 170'(rename_issueinfo[17:0]), 170'({6'd33, 6'd32, 6'd32}));
        checkOutput("second_old", 170'(rename_old_map), 170'(32));
        applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 1, 33, 0, 0);
        checkOutput("reader_maps", 170'(rename_issueinfo[17:0]), 170'({6'd0, 6'd0, 6'd33}));

        // Stall for three cycles with an instruction waiting
        saved_info = rename_issueinfo;
        saved_num  = rename_instr_num;
        for (int k = 0; k < 3; k++) applyStimulus(1, 4, 5, 6, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_info_held", rename_issueinfo, saved_info);
        checkOutput("stall_num_held", 170'(rename_instr_num), 170'(saved_num));
        applyStimulus(1, 4, 5, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("after_stall_num", 170'(rename_instr_num), 170'(3));
        idle(2);

        // Drain the free list, then free one register by commit
        do_reset();
        for (int k = 0; k < 33; k++)
            applyStimulus(1, 0, 0, 5'(((k + 4) % 31) + 1), 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("refill_map", 170'(rename_issueinfo[17:12]), 170'(5));
        idle(2);

        // Four renames, one commit of r3->32, then a flush
        do_reset();
        for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 5'(3 + k), 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("flush_enque", 170'(rename_enque), 170'(0));
        checkOutput("flush_busy", 170'(busy), 170'({64{1'b1}}));
        applyStimulus(1, 3, 4, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush_maps", 170'(rename_issueinfo[17:0]), 170'({6'd3, 6'd4, 6'd32}));
        idle(2);

        // Randomized traffic with legal in-order commits and broadcasts
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            st = ($urandom_range(0, 7) == 0);
            fl = !st && ($urandom_range(0, 49) == 0);
            cm = ($urandom_range(0, 2) == 0);
            v  = ($urandom_range(0, 3) != 0);
            wf = ($urandom_range(0, 4) != 0);
            eb = 1'b0; mb = 1'b0; em = '0; mm = '0;
            if (rob.size() > 0 && $urandom_range(0, 1) == 1) begin
                eb = 1'b1;
                em = rob[$urandom_range(0, rob.size() - 1)].nmap;
            end
            if (rob.size() > 0 && $urandom_range(0, 2) == 0) begin
                mb = 1'b1;
                mm = rob[$urandom_range(0, rob.size() - 1)].nmap;
            end else if ($urandom_range(0, 9) == 0) begin
                mb = 1'b1;
            end
            applyStimulus(v, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), wf, st, fl, cm, eb, em, mb, mm);
        end
        idle(3);
        checkOutput("scoreboard_empty", 170'(sb.size()), 170'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
